// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//
// Shares the single SDRAM controller between two requesters: the Wishbone
// slave path (port 0) and the FIR data mover (port 1). One port is granted at
// a time in round-robin order. The granted command is presented on the
// controller's in_valid/busy handshake. Read data coming back on
// ctrl_out_valid is routed to the granted port. A watchdog on the read
// response returns TIMEOUT_DATA with an error flag, so a lost out_valid
// cannot hang the shared controller.
//
// Parameters
//   RD_TIMEOUT    max cycles spent waiting for ctrl_out_valid after a read
//                 has been accepted (must be >= 2)
//   TIMEOUT_DATA  read data returned when a read times out
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pN_req_valid/we/addr/    request from port N (N = 0, 1); it is held
//   mask/wdata               stable until pN_req_ready
//   pN_req_ready             one-cycle accept pulse
//   pN_rsp_valid/rdata/err   registered one-cycle read response; rdata and
//                            err are 0 when rsp_valid is low
//   ctrl_in_valid/rw/addr/   command to the controller; every field is 0
//   mask/wdata               when no command is driven
//   ctrl_busy                controller cannot accept a command this cycle
//   ctrl_out_valid/rdata     read data pulse from the controller

module sdram_arbiter #(
    parameter int          RD_TIMEOUT   = 64,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req_valid,
    input  logic        p0_req_we,
    input  logic [22:0] p0_req_addr,
    input  logic [3:0]  p0_req_mask,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_req_ready,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_rdata,
    output logic        p0_rsp_err,

    input  logic        p1_req_valid,
    input  logic        p1_req_we,
    input  logic [22:0] p1_req_addr,
    input  logic [3:0]  p1_req_mask,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_req_ready,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_rdata,
    output logic        p1_rsp_err,

    output logic        ctrl_in_valid,
    output logic        ctrl_rw,
    output logic [22:0] ctrl_addr,
    output logic [3:0]  ctrl_mask,
    output logic [31:0] ctrl_wdata,
    input  logic        ctrl_busy,
    input  logic        ctrl_out_valid,
    input  logic [31:0] ctrl_rdata
);

    // The watchdog counts 0 .. RD_TIMEOUT-1 while waiting for read data.
    localparam int            TW    = $clog2(RD_TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } state_t;

    state_t        state;
    logic          grant;
    logic          last;
    logic [TW-1:0] tcnt;

    logic          winner;
    logic          issuing;
    logic          accept;
    logic          sel_we;
    logic [22:0]   sel_addr;
    logic [3:0]    sel_mask;
    logic [31:0]   sel_wdata;

    // Round-robin pick. On a tie the port that was not served last wins.
    // With a single requester that port wins. When nobody requests, the value
    // is unused.
    always_comb begin
        winner = p1_req_valid;
        if (p0_req_valid && p1_req_valid) begin
            winner = ~last;
        end
    end

    // Route the granted port's request fields towards the controller. The
    // requester holds its fields stable until accepted, so the live inputs
    // are forwarded rather than a registered copy.
    always_comb begin
        sel_we    = p0_req_we;
        sel_addr  = p0_req_addr;
        sel_mask  = p0_req_mask;
        sel_wdata = p0_req_wdata;
        if (grant) begin
            sel_we    = p1_req_we;
            sel_addr  = p1_req_addr;
            sel_mask  = p1_req_mask;
            sel_wdata = p1_req_wdata;
        end
    end

    // Command outputs are live only in ISSUE and forced to zero otherwise.
    // A read never carries byte enables, so the mask is gated with we.
    assign issuing       = (state == ISSUE);
    assign accept        = issuing && !ctrl_busy;
    assign ctrl_in_valid = issuing;
    assign ctrl_rw       = issuing && sel_we;
    assign ctrl_addr     = issuing ? sel_addr : 23'd0;
    assign ctrl_mask     = issuing ? (sel_mask & {4{sel_we}}) : 4'd0;
    assign ctrl_wdata    = issuing ? sel_wdata : 32'd0;

    // The accept pulse reaches the granted port in the same cycle in which
    // the controller takes the command.
    assign p0_req_ready  = accept && !grant;
    assign p1_req_ready  = accept &&  grant;

    // Main sequencer. Only one transaction is ever in flight. A read parks
    // the arbiter in WAIT_RD until the data or the watchdog answers, so a
    // new command is never issued while a read is outstanding. The response
    // registers default to zero every cycle, which makes them one-cycle
    // pulses. Out_valid arriving in IDLE or ISSUE (a stray response, or a
    // late one after a timeout or reset) falls through without effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last         <= 1'b1;
            tcnt         <= '0;
            p0_rsp_valid <= 1'b0;
            p0_rsp_rdata <= 32'd0;
            p0_rsp_err   <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_rdata <= 32'd0;
            p1_rsp_err   <= 1'b0;
        end else begin
            p0_rsp_valid <= 1'b0;
            p0_rsp_rdata <= 32'd0;
            p0_rsp_err   <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_rdata <= 32'd0;
            p1_rsp_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (p0_req_valid || p1_req_valid) begin
                        grant <= winner;
                        last  <= winner;
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (!ctrl_busy) begin
                        if (sel_we) begin
                            state <= IDLE;
                        end else begin
                            tcnt  <= '0;
                            state <= WAIT_RD;
                        end
                    end
                end

                WAIT_RD: begin
                    // Real data takes priority over a watchdog expiry in the
                    // same cycle.
                    if (ctrl_out_valid || (tcnt == TLAST)) begin
                        if (grant) begin
                            p1_rsp_valid <= 1'b1;
                            p1_rsp_rdata <= ctrl_out_valid ? ctrl_rdata : TIMEOUT_DATA;
                            p1_rsp_err   <= !ctrl_out_valid;
                        end else begin
                            p0_rsp_valid <= 1'b1;
                            p0_rsp_rdata <= ctrl_out_valid ? ctrl_rdata : TIMEOUT_DATA;
                            p0_rsp_err   <= !ctrl_out_valid;
                        end
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//
// Bench for sdram_arbiter. Requests are posted through applyStimulus, which
// also queues the command that the controller should later see. A monitor
// watches the DUT every falling edge. It matches accepted commands against
// those queues and checks the round-robin order. When a read is accepted, it
// plays the controller: it chooses when (or whether) out_valid comes back and
// queues the response the requester should get, computed from plain cycle
// arithmetic. Every response pulse is then matched against that queue.

module tb_sdram_arbiter;

    localparam int          RD_TIMEOUT   = 8;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        p0_req_valid = 1'b0, p0_req_we = 1'b0;
    logic [22:0] p0_req_addr = '0;
    logic [3:0]  p0_req_mask = '0;
    logic [31:0] p0_req_wdata = '0;
    logic        p0_req_ready, p0_rsp_valid, p0_rsp_err;
    logic [31:0] p0_rsp_rdata;

    logic        p1_req_valid = 1'b0, p1_req_we = 1'b0;
    logic [22:0] p1_req_addr = '0;
    logic [3:0]  p1_req_mask = '0;
    logic [31:0] p1_req_wdata = '0;
    logic        p1_req_ready, p1_rsp_valid, p1_rsp_err;
    logic [31:0] p1_rsp_rdata;

    logic        ctrl_in_valid, ctrl_rw;
    logic [22:0] ctrl_addr;
    logic [3:0]  ctrl_mask;
    logic [31:0] ctrl_wdata;
    logic        ctrl_busy = 1'b0, ctrl_out_valid = 1'b0;
    logic [31:0] ctrl_rdata = '0;

    sdram_arbiter #(
        .RD_TIMEOUT  (RD_TIMEOUT),
        .TIMEOUT_DATA(TIMEOUT_DATA)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
        .p0_req_mask(p0_req_mask), .p0_req_wdata(p0_req_wdata), .p0_req_ready(p0_req_ready),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
        .p1_req_mask(p1_req_mask), .p1_req_wdata(p1_req_wdata), .p1_req_ready(p1_req_ready),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
        .ctrl_in_valid(ctrl_in_valid), .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr),
        .ctrl_mask(ctrl_mask), .ctrl_wdata(ctrl_wdata), .ctrl_busy(ctrl_busy),
        .ctrl_out_valid(ctrl_out_valid), .ctrl_rdata(ctrl_rdata)
    );

    typedef struct packed {
        logic        we;
        logic [22:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    cmd_t  cmd_q0[$];
    cmd_t  cmd_q1[$];
    rsp_t  rsp_q[$];

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    // Knobs shared between the stimulus and the controller/monitor processes.
    logic        rand_mode = 1'b0;
    logic        dir_busy = 1'b0;
    int          dir_delay = 3;
    logic [31:0] dir_data = '0;
    int          ov_cycle = -100;
    logic [31:0] ov_data = '0;
    int          stray_cycle = -100;
    logic        cont_active = 1'b0;
    int          cont_start = 0;
    int          last_rdy[2] = '{-1000, -1000};
    int          must_next = -1;

    // 100 MHz clock and a cycle index that counts rising edges.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: bump the count, report any mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Posts one request on a port and holds it until accepted. Entry is
    // expected right after a rising edge. Returns the cycle of acceptance.
    task automatic applyStimulus(input int port, input logic we, input logic [22:0] addr,
                                 input logic [3:0] mask, input logic [31:0] wdata,
                                 output int acc_cycle);
        cmd_t c;
        bit   got;
        c = '{we: we, addr: addr, mask: mask, wdata: wdata};
        if (port == 0) begin
            cmd_q0.push_back(c);
            p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = addr;
            p0_req_mask = mask; p0_req_wdata = wdata;
        end else begin
            cmd_q1.push_back(c);
            p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = addr;
            p1_req_mask = mask; p1_req_wdata = wdata;
        end
        got = 1'b0;
        acc_cycle = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if ((port == 0 && p0_req_ready) || (port == 1 && p1_req_ready)) begin
                got = 1'b1;
                acc_cycle = cyc;
            end
        end
        if (!got) checkOutput("req_ready wait", 0, 1);
        @(posedge clk);
        #1;
        if (port == 0) p0_req_valid = 1'b0;
        else           p1_req_valid = 1'b0;
    endtask

    // Waits (bounded) until every expected response has been seen.
    task automatic waitDrain();
        for (int i = 0; i < 60 && rsp_q.size() != 0; i++) @(negedge clk);
        checkOutput("rsp drain", rsp_q.size(), 0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " p0"}, {p0_req_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata}, 0);
        checkOutput({name, " p1"}, {p1_req_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata}, 0);
        checkOutput({name, " ctrl"}, {ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_mask, ctrl_wdata}, 0);
    endtask

    task automatic randomDriver(input int port, input int n);
        int          acc;
        logic        we;
        logic [22:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            we    = 1'($urandom_range(0, 1));
            addr  = 23'($urandom);
            mask  = 4'($urandom);
            wdata = $urandom;
            applyStimulus(port, we, addr, mask, wdata, acc);
        end
    endtask

    // Controller model outputs, driven a little after each rising edge so
    // they never race the stimulus writes made at +1.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            ctrl_busy      = rand_mode ? ($urandom_range(0, 3) == 0) : dir_busy;
            ctrl_out_valid = (cyc == ov_cycle) || (cyc == stray_cycle);
            ctrl_rdata     = (cyc == ov_cycle) ? ov_data : $urandom;
        end
    end

    // Monitor / scoreboard.
    initial begin
        int   port;
        int   d;
        cmd_t c;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_q.delete();
                must_next = -1;
            end else begin
                if (!p0_rsp_valid) checkOutput("p0 rsp quiet", {p0_rsp_err, p0_rsp_rdata}, 0);
                if (!p1_rsp_valid) checkOutput("p1 rsp quiet", {p1_rsp_err, p1_rsp_rdata}, 0);
                if (!ctrl_in_valid)
                    checkOutput("ctrl quiet", {ctrl_rw, ctrl_addr, ctrl_mask, ctrl_wdata}, 0);

                if (p0_req_ready || p1_req_ready) begin
                    if (p0_req_ready && p1_req_ready) checkOutput("dual ready", 1, 0);
                    port = p1_req_ready ? 1 : 0;
                    checkOutput("ready handshake", {ctrl_in_valid, ctrl_busy}, 2'b10);
                    if (must_next >= 0) checkOutput("round robin port", port, must_next);
                    must_next = ((port == 0) ? p1_req_valid : p0_req_valid) ? (1 - port) : -1;
                    if (cont_active && last_rdy[port] >= cont_start)
                        checkOutput("contention interval", cyc - last_rdy[port], 4);
                    last_rdy[port] = cyc;

                    if ((port == 0 && cmd_q0.size() == 0) || (port == 1 && cmd_q1.size() == 0)) begin
                        checkOutput("unexpected accept", 1, 0);
                    end else begin
                        c = (port == 0) ? cmd_q0.pop_front() : cmd_q1.pop_front();
                        checkOutput("cmd fields", {ctrl_rw, ctrl_addr, ctrl_mask, ctrl_wdata},
                                    {c.we, c.addr, c.mask & {4{c.we}}, c.wdata});
                        if (!c.we) begin
                            d = rand_mode ? int'($urandom_range(1, RD_TIMEOUT + 2)) : dir_delay;
                            ov_data  = rand_mode ? $urandom : dir_data;
                            ov_cycle = cyc + d;
                            e.port = port;
                            if (d <= RD_TIMEOUT) begin
                                e.data = ov_data;  e.err = 1'b0; e.cyc = cyc + d + 1;
                            end else begin
                                e.data = TIMEOUT_DATA; e.err = 1'b1; e.cyc = cyc + RD_TIMEOUT + 1;
                            end
                            rsp_q.push_back(e);
                        end
                    end
                end

                if (p0_rsp_valid || p1_rsp_valid) begin
                    if (p0_rsp_valid && p1_rsp_valid) checkOutput("dual rsp", 1, 0);
                    if (rsp_q.size() == 0) begin
                        checkOutput("unexpected rsp", 1, 0);
                    end else begin
                        e = rsp_q.pop_front();
                        port = p1_rsp_valid ? 1 : 0;
                        checkOutput("rsp port", port, e.port);
                        checkOutput("rsp data", port ? p1_rsp_rdata : p0_rsp_rdata, e.data);
                        checkOutput("rsp err", port ? p1_rsp_err : p0_rsp_err, e.err);
                        checkOutput("rsp cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    // Global time limit.
    initial begin
        repeat (50000) @(posedge clk);
        $display("[TB] FAIL watchdog: bench did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] time limit");
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        int acc;
        int t0;

        // Reset state, then a stray out_valid in IDLE must stay silent.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        stray_cycle = cyc + 1;
        repeat (4) @(posedge clk);
        #1;

        // Single write on port 0: command and accept the cycle after request.
        $display("[TB] single write");
        t0 = cyc;
        applyStimulus(0, 1'b1, 23'h000010, 4'hF, 32'h1234_5678, acc);
        checkOutput("write accept latency", acc - t0, 1);
        @(negedge clk);
        checkOutput("idle after write", ctrl_in_valid, 0);
        @(posedge clk);
        #1;

        // Single read on port 1, data 5 cycles after accept.
        $display("[TB] single read");
        dir_delay = 5;
        dir_data  = 32'hCAFE_F00D;
        applyStimulus(1, 1'b0, 23'h000020, 4'h3, 32'h0, acc);
        waitDrain();

        // Data arriving on the last watchdog cycle wins over the timeout.
        dir_delay = RD_TIMEOUT;
        dir_data  = 32'h0BAD_CAFE;
        applyStimulus(0, 1'b0, 23'h000024, 4'h0, 32'h0, acc);
        waitDrain();

        // Contention: both ports post writes back to back.
        $display("[TB] contention");
        cont_start  = cyc;
        cont_active = 1'b1;
        fork
            begin
                int a0;
                for (int i = 0; i < 4; i++)
                    applyStimulus(0, 1'b1, 23'(32'h100 + i), 4'hF, 32'hA000_0000 + i, a0);
            end
            begin
                int a1;
                for (int i = 0; i < 4; i++)
                    applyStimulus(1, 1'b1, 23'(32'h200 + i), 4'h5, 32'hB000_0000 + i, a1);
            end
        join
        cont_active = 1'b0;
        waitDrain();

        // Busy backpressure for 7 cycles in ISSUE.
        $display("[TB] busy backpressure");
        dir_busy = 1'b1;
        t0 = cyc;
        fork
            applyStimulus(0, 1'b1, 23'h000040, 4'h6, 32'hA5A5_0F0F, acc);
            begin
                @(negedge clk);
                repeat (7) begin
                    @(negedge clk);
                    checkOutput("busy hold",
                                {ctrl_in_valid, p0_req_ready, p1_req_ready,
                                 ctrl_rw, ctrl_addr, ctrl_mask, ctrl_wdata},
                                {3'b100, 1'b1, 23'h000040, 4'h6, 32'hA5A5_0F0F});
                end
                @(posedge clk);
                #1;
                dir_busy = 1'b0;
            end
        join
        checkOutput("busy accept cycle", acc - t0, 8);
        waitDrain();

        // Timeout with a late out_valid, then a normal read.
        $display("[TB] read timeout");
        dir_delay = RD_TIMEOUT + 2;
        dir_data  = 32'h1111_1111;
        applyStimulus(0, 1'b0, 23'h000030, 4'h0, 32'h0, acc);
        waitDrain();
        dir_delay = 2;
        dir_data  = 32'h5A5A_C3C3;
        applyStimulus(1, 1'b0, 23'h000034, 4'h0, 32'h0, acc);
        waitDrain();

        // Reset while a read is outstanding: no response, late data ignored.
        $display("[TB] reset during read");
        dir_delay = 6;
        dir_data  = 32'h7777_7777;
        applyStimulus(1, 1'b0, 23'h000050, 4'h0, 32'h0, acc);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("mid reset");
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 23'h000060, 4'hC, 32'hFEED_0001, acc);
        waitDrain();

        // Randomized traffic from both ports with random busy and delays.
        $display("[TB] random traffic");
        rand_mode = 1'b1;
        fork
            randomDriver(0, 40);
            randomDriver(1, 40);
        join
        waitDrain();
        checkOutput("cmd queues empty", cmd_q0.size() + cmd_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter that shares the single SDRAM controller in the user project between the Wishbone slave path (port 0) and the FIR data mover (port 1). It grants one port at a time in round-robin order and sequences one command into the controller's in_valid/busy handshake. Read data returns on the controller's out_valid pulse and is routed back to the granted port. A read-response watchdog keeps a lost out_valid from hanging the shared resource.

## Interface
- RD_TIMEOUT, 64: max cycles spent waiting for ctrl_out_valid after a read is accepted (≥2).
- TIMEOUT_DATA, 32'hDEAD_BEEF: data returned on a timed-out read.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pN_req_valid  in  1  port N (N=0,1) request; held with fields stable until pN_req_ready.
- pN_req_we  in  1  1 = write, 0 = read.
- pN_req_addr  in  23  SDRAM word address.
- pN_req_mask  in  4  byte enables for writes.
- pN_req_wdata  in  32  write data.
- pN_req_ready  out  1  one-cycle accept pulse.
- pN_rsp_valid  out  1  one-cycle read-response pulse.
- pN_rsp_rdata  out  32  read data; valid with pN_rsp_valid, 0 otherwise.
- pN_rsp_err  out  1  high with pN_rsp_valid when the read timed out.
- ctrl_in_valid  out  1  command valid to controller.
- ctrl_rw  out  1  granted port's we; 0 when no command is driven.
- ctrl_addr  out  23  granted port's address; 0 when no command is driven.
- ctrl_mask  out  4  granted mask AND {4{we}}; 0 when no command is driven.
- ctrl_wdata  out  32  granted write data; 0 when no command is driven.
- ctrl_busy  in  1  controller cannot accept.
- ctrl_out_valid  in  1  read data valid pulse.
- ctrl_rdata  in  32  read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD. Registers: state, grant (1 b), last (1 b), tcnt.
- IDLE:
  - If any pN_req_valid is high, pick a winner. If both are high, the port ≠ last wins. Otherwise the single requester wins.
  - Register grant, set last = winner, go to ISSUE.
- ISSUE:
  - ctrl_in_valid=1; ctrl_* fields are the granted port's fields.
  - Accept occurs when ctrl_busy=0. On accept, p[grant]_req_ready=1 (combinational: state==ISSUE && grant==N && !ctrl_busy).
  - After accept: a write goes to IDLE; a read clears tcnt and goes to WAIT_RD.
  - While ctrl_busy=1, stay in ISSUE.
- WAIT_RD:
  - ctrl_in_valid=0.
  - On ctrl_out_valid: p[grant]_rsp_valid=1, rsp_rdata=ctrl_rdata, rsp_err=0, go to IDLE.
  - Otherwise, when tcnt==RD_TIMEOUT-1: rsp_valid=1, rsp_rdata=TIMEOUT_DATA, rsp_err=1, go to IDLE.
  - Otherwise tcnt+1.
- If out_valid and timeout coincide, out_valid wins.
- ctrl_out_valid in IDLE or ISSUE is a stray or late response; it is ignored and produces no rsp pulse.
- Response outputs are registered. The non-granted port's rsp_* stay 0.
- A requester dropping req_valid before ready is illegal. The arbiter still issues the latched grant's fields as presented.

## Timing
- Reset values: state=IDLE, last=1 (port 0 wins first tie), grant=0, tcnt=0. All outputs are 0.
- Reset mid-operation: next cycle is IDLE. Any outstanding read is dropped with no rsp pulse, and a later out_valid is ignored.
- Request latency: req_valid rising in IDLE at cycle T gives ctrl_in_valid and req_ready at T+1 if ctrl_busy=0.
- Throughput: minimum 2 cycles per write (ISSUE, IDLE).
- Read response: pN_rsp_valid appears the cycle after ctrl_out_valid is sampled.
- Timeout: rsp_err pulse in the cycle after RD_TIMEOUT cycles in WAIT_RD.
- A new command is never issued while a read is outstanding; only one transaction is ever in flight.

## Test plan
- Single write: p0 write addr 0x000010, wdata 0x12345678, mask 0xF, ctrl_busy=0 → ctrl_in_valid, ctrl_rw=1 and ctrl_mask=0xF at T+1; p0_req_ready at T+1; no rsp; IDLE at T+2.
- Single read: p1 read 0x000020; controller returns out_valid with 0xCAFEF00D 5 cycles after accept → p1_rsp_valid one cycle later with rdata 0xCAFEF00D, err=0; p0 rsp stays 0.
- Contention: both ports continuously post writes → grants alternate 0,1,0,1; each port sees one req_ready per 4 cycles.
- Busy backpressure: ctrl_busy=1 for 7 cycles during ISSUE → ctrl_in_valid stays high with stable fields; req_ready only in the first cycle busy=0.
- Timeout: RD_TIMEOUT=8, no out_valid → rsp_valid with 0xDEADBEEF and rsp_err=1; a late out_valid is ignored; the next request is served normally.
- Reset during WAIT_RD → all outputs 0 the next cycle, no rsp pulse; a subsequent out_valid is ignored.
